// File: rtl/obi_irq_resp_pkg.sv
// obi_irq_resp_pkg: register map, mip bit positions, interrupt IDs and TCTRL fields
// shared by the OBI interrupt responder and its timer.
package obi_irq_resp_pkg;

    typedef enum logic [2:0] {
        OFF_PEND_SET  = 3'd0,
        OFF_PEND_CLR  = 3'd1,
        OFF_FASTX_SET = 3'd2,
        OFF_FASTX_CLR = 3'd3,
        OFF_MTIME     = 3'd4,
        OFF_MTIMECMP  = 3'd5,
        OFF_TCTRL     = 3'd6,
        OFF_ACKCNT    = 3'd7
    } reg_off_e;

    localparam int MIP_SOFTWARE = 3;
    localparam int MIP_TIMER    = 7;
    localparam int MIP_EXTERNAL = 11;
    localparam int MIP_FAST_LO  = 16;
    localparam int MIP_FAST_HI  = 30;
    localparam int MIP_NMI      = 31;

    localparam logic [4:0] IRQ_ID_SOFTWARE = 5'd3;
    localparam logic [4:0] IRQ_ID_TIMER    = 5'd7;
    localparam logic [4:0] IRQ_ID_EXTERNAL = 5'd11;
    localparam logic [4:0] IRQ_ID_FAST0    = 5'd16;
    localparam logic [4:0] IRQ_ID_NMI      = 5'd31;

    localparam logic [31:0] PEND_MASK = 32'hFFFF_0888;

    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_RELOAD = 1;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Interrupt IDs coincide with mip bit positions, so an ID selects its bit directly.
    function automatic logic [31:0] id_to_mip(input logic [4:0] id);
        return (32'h1 << id) & PEND_MASK;
    endfunction

endpackage

// File: rtl/obi_irq_resp_timer.sv
// obi_irq_resp_timer: MTIME/MTIMECMP/TCTRL with compare and auto-reload; match_o pulses
// in the cycle where the enabled counter equals the compare value.
module obi_irq_resp_timer
    import obi_irq_resp_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_i,
    input  logic [2:0]  off_i,
    input  logic [31:0] wmask_i,
    input  logic [31:0] wbits_i,
    output logic [31:0] rdata_o,
    output logic        match_o
);

    localparam int unsigned W = TIMER_WIDTH;

    logic [W-1:0] mtime_q, mtime_d, mtime_nxt, cmp_q, cmp_d, mask, bits;
    logic [1:0]   tctrl_q, tctrl_d;
    logic         en;

    assign mask    = wmask_i[W-1:0];
    assign bits    = wbits_i[W-1:0];
    assign en      = tctrl_q[TCTRL_EN];
    assign match_o = en && (mtime_q == cmp_q);

    // A bus write to MTIME overrides the increment/reload of the same cycle.
    always_comb begin
        mtime_nxt = !en ? mtime_q : (match_o && tctrl_q[TCTRL_RELOAD]) ? '0 : mtime_q + W'(1);
        mtime_d   = (wr_i && off_i == OFF_MTIME) ? ((mtime_q & ~mask) | bits) : mtime_nxt;
        cmp_d     = (wr_i && off_i == OFF_MTIMECMP) ? ((cmp_q & ~mask) | bits) : cmp_q;
        tctrl_d   = (wr_i && off_i == OFF_TCTRL) ? ((tctrl_q & ~mask[1:0]) | bits[1:0]) : tctrl_q;
        rdata_o   = (off_i == OFF_MTIME)    ? 32'(mtime_q) :
                    (off_i == OFF_MTIMECMP) ? 32'(cmp_q) :
                    (off_i == OFF_TCTRL)    ? 32'(tctrl_q) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            tctrl_q <= '0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            tctrl_q <= tctrl_d;
        end
    end

endmodule

// File: rtl/obi_irq_responder.sv
// obi_irq_responder: OBI responder raising core interrupts via W1S/W1C registers, a compare
// timer and ack clearing. Define OBI_IRQ_RESP_FASTX_EN to implement FASTX and irq_fastx_o.
module obi_irq_responder
    import obi_irq_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1500_0000,
    parameter int unsigned TIMER_WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_i,
    output logic        irq_software_o,
    output logic        irq_timer_o,
    output logic        irq_external_o,
    output logic        irq_nmi_o,
    output logic [14:0] irq_fast_o,
    output logic [31:0] irq_fastx_o
);

    logic [2:0]  off;
    logic        wr, match, rvalid_q, unused_addr;
    logic [31:0] wmask, wbits, pend_set, pend_clr, pend_d, pend_q;
    logic [31:0] fastx_rd, tmr_rdata, rdata_d, rdata_q;
    logic [15:0] ackcnt_q;
    logic [4:0]  ackid_q;

    assign off         = data_addr_i[4:2];
    assign wr          = data_req_i && data_we_i;
    assign wmask       = be_mask(data_be_i);
    assign wbits       = data_wdata_i & wmask;
    assign unused_addr = ^{BASE_ADDR, data_addr_i[31:5], data_addr_i[1:0]};

    obi_irq_resp_timer #(
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wr_i   (wr),
        .off_i  (off),
        .wmask_i(wmask),
        .wbits_i(wbits),
        .rdata_o(tmr_rdata),
        .match_o(match)
    );

    // Set is OR-ed in after clearing, so a same-cycle set beats W1C or ack.
    always_comb begin
        pend_set = ((wr && off == OFF_PEND_SET) ? wbits : '0) | (match ? (32'h1 << MIP_TIMER) : '0);
        pend_clr = ((wr && off == OFF_PEND_CLR) ? wbits : '0) | (irq_ack_i ? id_to_mip(irq_id_i) : '0);
        pend_d   = ((pend_q & ~pend_clr) | pend_set) & PEND_MASK;
    end

`ifdef OBI_IRQ_RESP_FASTX_EN
    logic [31:0] fastx_q, fastx_d;

    assign fastx_d = (wr && off == OFF_FASTX_SET) ? (fastx_q | wbits) :
                     (wr && off == OFF_FASTX_CLR) ? (fastx_q & ~wbits) : fastx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fastx_q <= '0;
        else         fastx_q <= fastx_d;
    end

    assign fastx_rd    = fastx_q;
    assign irq_fastx_o = fastx_q;
`else
    assign fastx_rd    = '0;
    assign irq_fastx_o = '0;
`endif

    // Read data is captured at the grant edge; writes and idle cycles return 0.
    assign rdata_d = (!data_req_i || data_we_i)                     ? '0 :
                     (off == OFF_PEND_SET || off == OFF_PEND_CLR)   ? pend_q :
                     (off == OFF_FASTX_SET)                         ? fastx_rd :
                     (off == OFF_ACKCNT)                            ? {11'd0, ackid_q, ackcnt_q} :
                                                                      tmr_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q   <= '0;
            ackcnt_q <= '0;
            ackid_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            rvalid_q <= data_req_i;
            rdata_q  <= rdata_d;
            if (irq_ack_i) begin
                ackcnt_q <= ackcnt_q + 16'd1;
                ackid_q  <= irq_id_i;
            end
        end
    end

    assign data_gnt_o     = data_req_i;
    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign irq_software_o = pend_q[MIP_SOFTWARE];
    assign irq_timer_o    = pend_q[MIP_TIMER];
    assign irq_external_o = pend_q[MIP_EXTERNAL];
    assign irq_nmi_o      = pend_q[MIP_NMI];
    assign irq_fast_o     = pend_q[MIP_FAST_HI:MIP_FAST_LO];

endmodule
